// File: rtl/edge_sync.sv
// Two-flop synchronizer plus history flop for an asynchronous input.
// Produces a one-clock pulse on each synchronized rising edge.
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic s1_r;
   logic s2_r;
   logic s3_r;

   // Metastability chain followed by the history flop used for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= din;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a fixed
// gate window of GATE_CYCLES clocks and publishes the result once per window.
module freq_meter #(
   parameter int unsigned CLK_FREQ = 32'd50_000_000,
   parameter int unsigned GATE_MS  = 32'd1000,
   parameter int unsigned CNT_W    = 32'd32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam int unsigned      GATE_CYCLES = (CLK_FREQ / 32'd1000) * GATE_MS;
   localparam logic [31:0]      GATE_LAST   = 32'(GATE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ALL1    = {CNT_W{1'b1}};

   state_t             state_r, state_s;
   logic [31:0]        gate_cnt_r, gate_cnt_s;
   logic [CNT_W-1:0]   edge_cnt_r, edge_cnt_s;
   logic               win_ovf_r, win_ovf_s;
   logic [CNT_W-1:0]   count_r, count_s;
   logic               count_valid_r, count_valid_s;
   logic               overflow_r, overflow_s;
   logic               rise_s;
   logic [CNT_W-1:0]   edge_next_s;
   logic               ovf_hit_s;

   edge_sync u_edge_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sig_in),
      .rise  (rise_s)
   );

   // Saturating edge count including this cycle's edge, so the terminal cycle can publish it
   always_comb begin
      edge_next_s = edge_cnt_r;
      ovf_hit_s   = 1'b0;
      if (rise_s) begin
         if (edge_cnt_r == CNT_ALL1) begin
            ovf_hit_s = 1'b1;
         end else begin
            edge_next_s = edge_cnt_r + CNT_ONE;
         end
      end else begin
         edge_next_s = edge_cnt_r;
      end
   end

   // Next-state and next-value logic for the gate window controller
   always_comb begin
      state_s       = state_r;
      gate_cnt_s    = gate_cnt_r;
      edge_cnt_s    = edge_cnt_r;
      win_ovf_s     = win_ovf_r;
      count_s       = count_r;
      count_valid_s = 1'b0;
      overflow_s    = overflow_r;
      case (state_r)
         IDLE: begin
            gate_cnt_s = 32'd0;
            edge_cnt_s = {CNT_W{1'b0}};
            win_ovf_s  = 1'b0;
            if (enable) begin
               state_s = MEASURE;
            end else begin
               state_s = IDLE;
            end
         end
         MEASURE: begin
            if (gate_cnt_r == GATE_LAST) begin
               // Publish even if enable just dropped; the window is complete
               count_s       = edge_next_s;
               count_valid_s = 1'b1;
               overflow_s    = overflow_r | win_ovf_r | ovf_hit_s;
               gate_cnt_s    = 32'd0;
               edge_cnt_s    = {CNT_W{1'b0}};
               win_ovf_s     = 1'b0;
               if (enable) begin
                  state_s = MEASURE;
               end else begin
                  state_s = IDLE;
               end
            end else if (!enable) begin
               state_s    = IDLE;
               gate_cnt_s = 32'd0;
               edge_cnt_s = {CNT_W{1'b0}};
               win_ovf_s  = 1'b0;
            end else begin
               gate_cnt_s = gate_cnt_r + 32'd1;
               edge_cnt_s = edge_next_s;
               win_ovf_s  = win_ovf_r | ovf_hit_s;
            end
         end
         default: begin
            state_s    = IDLE;
            gate_cnt_s = 32'd0;
            edge_cnt_s = {CNT_W{1'b0}};
            win_ovf_s  = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         gate_cnt_r    <= 32'd0;
         edge_cnt_r    <= {CNT_W{1'b0}};
         win_ovf_r     <= 1'b0;
         count_r       <= {CNT_W{1'b0}};
         count_valid_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         state_r       <= state_s;
         gate_cnt_r    <= gate_cnt_s;
         edge_cnt_r    <= edge_cnt_s;
         win_ovf_r     <= win_ovf_s;
         count_r       <= count_s;
         count_valid_r <= count_valid_s;
         overflow_r    <= overflow_s;
      end
   end

   assign count       = count_r;
   assign count_valid = count_valid_r;
   assign overflow    = overflow_r;
   assign busy        = (state_r == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Randomized self-checking bench for freq_meter: two instances (32-bit and
// 4-bit counters) share stimulus and are compared against a window-level model.
module tb_freq_meter;

   localparam int GATE = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        sig_in = 1'b0;
   logic [31:0] count32;
   logic        valid32, ovf32, busy32;
   logic [3:0]  count4;
   logic        valid4, ovf4, busy4;

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus controls
   int  pat  = 0;
   bit  en_v = 1'b0;
   int  cyc  = 0;

   // reference model state
   logic        samp[$];
   bit          m_active;
   int          m_pos;
   int          m_edges;
   logic [31:0] e_count32;
   logic [3:0]  e_count4;
   bit          e_valid, e_ovf32, e_ovf4;

   freq_meter #(.CLK_FREQ(32'd100_000), .GATE_MS(32'd1), .CNT_W(32'd32)) dut32 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
      .count(count32), .count_valid(valid32), .overflow(ovf32), .busy(busy32));

   freq_meter #(.CLK_FREQ(32'd100_000), .GATE_MS(32'd1), .CNT_W(32'd4)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
      .count(count4), .count_valid(valid4), .overflow(ovf4), .busy(busy4));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic pat_val(input int p, input int c);
      case (p)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return 1'((c / 2) % 2);
         3:       return 1'(c % 2);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic model_reset();
      samp = '{1'b0, 1'b0, 1'b0};
      m_active  = 1'b0;
      m_pos     = 0;
      m_edges   = 0;
      e_count32 = 32'd0;
      e_count4  = 4'd0;
      e_valid   = 1'b0;
      e_ovf32   = 1'b0;
      e_ovf4    = 1'b0;
   endtask

   task automatic check_outputs();
      check_eq("count32", 64'(count32), 64'(e_count32));
      check_eq("valid32", 64'(valid32), 64'(e_valid));
      check_eq("ovf32",   64'(ovf32),   64'(e_ovf32));
      check_eq("busy32",  64'(busy32),  64'(m_active));
      check_eq("count4",  64'(count4),  64'(e_count4));
      check_eq("valid4",  64'(valid4),  64'(e_valid));
      check_eq("ovf4",    64'(ovf4),    64'(e_ovf4));
      check_eq("busy4",   64'(busy4),   64'(m_active));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_count32"}, 64'(count32), 64'd0);
      check_eq({tag, "_valid32"}, 64'(valid32), 64'd0);
      check_eq({tag, "_ovf32"},   64'(ovf32),   64'd0);
      check_eq({tag, "_busy32"},  64'(busy32),  64'd0);
      check_eq({tag, "_count4"},  64'(count4),  64'd0);
      check_eq({tag, "_ovf4"},    64'(ovf4),    64'd0);
   endtask

   // One clock: drive inputs, advance the window model, compare
   task automatic step();
      logic r;
      @(negedge clk);
      sig_in = pat_val(pat, cyc);
      enable = en_v;
      cyc++;
      @(posedge clk);
      // an input rise becomes visible to the counter two samples later
      r = samp[1] & ~samp[0];
      void'(samp.pop_front());
      samp.push_back(sig_in);
      e_valid = 1'b0;
      if (!m_active) begin
         if (enable) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_edges  = 0;
         end
      end else begin
         m_edges += int'(r);
         if (m_pos == GATE - 1) begin
            e_count32 = 32'(m_edges);
            e_count4  = (m_edges > 15) ? 4'd15 : 4'(m_edges);
            e_ovf4    = e_ovf4 | (m_edges > 15);
            e_valid   = 1'b1;
            m_pos     = 0;
            m_edges   = 0;
            if (!enable) m_active = 1'b0;
         end else if (!enable) begin
            m_active = 1'b0;
         end else begin
            m_pos++;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic run_until_pos(input int p, input int pt);
      int n;
      pat = pt;
      n = 0;
      do begin
         step();
         n++;
      end while (!(m_active && m_pos == p) && n < 400);
      if (n >= 400) check_eq("run_until_pos_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!valid32 && n < 300);
   endtask

   initial begin
      int n;
      int pulses;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      #3 rst_n = 1'b1;

      // continuous period-4 input
      en_v = 1'b1;
      pat = 2;
      pulses = 0;
      repeat (320) begin
         step();
         pulses += int'(valid32);
      end
      check_eq("p4_pulses", 64'(pulses), 64'd3);
      check_eq("p4_count", 64'(count32), 64'd25);

      // held high then low
      run_until_pos(0, 0);
      run_until_pos(0, 1);
      check_eq("single_rise", 64'(count32), 64'd1);
      run_until_pos(0, 1);
      check_eq("held_high", 64'(count32), 64'd0);
      check_eq("held_high_valid", 64'(valid32), 64'd1);
      run_until_pos(0, 0);
      check_eq("held_low", 64'(count32), 64'd0);

      // rise landing on the terminal cycle, then on cycle 0 of the next window
      run_until_pos(50, 0);
      run_until_pos(97, 0);
      run_until_pos(0, 1);
      check_eq("rise_cycle99", 64'(count32), 64'd1);
      run_until_pos(10, 0);
      run_until_pos(98, 0);
      run_until_pos(0, 1);
      check_eq("pre_cycle0", 64'(count32), 64'd0);
      run_until_pos(0, 1);
      check_eq("rise_cycle0", 64'(count32), 64'd1);

      // abort mid-window and re-enable
      run_until_pos(0, 2);
      run_until_pos(0, 2);
      check_eq("p4_before_abort", 64'(count32), 64'd25);
      run_until_pos(50, 2);
      en_v = 1'b0;
      step();
      check_eq("abort_busy", 64'(busy32), 64'd0);
      check_eq("abort_keep_count", 64'(count32), 64'd25);
      pulses = 0;
      repeat (5) begin
         step();
         pulses += int'(valid32);
      end
      check_eq("abort_no_pulse", 64'(pulses), 64'd0);
      en_v = 1'b1;
      wait_valid(n);
      check_eq("reenable_latency", 64'(n), 64'd101);

      // period-2 saturates the 4-bit counter
      run_until_pos(0, 3);
      run_until_pos(0, 3);
      check_eq("p2_count32", 64'(count32), 64'd50);
      check_eq("p2_count4_sat", 64'(count4), 64'd15);
      check_eq("p2_ovf4", 64'(ovf4), 64'd1);
      run_until_pos(0, 1);
      check_eq("ovf4_sticky", 64'(ovf4), 64'd1);

      // random input with random enable toggling
      pat = 4;
      repeat (800) begin
         if ($urandom_range(0, 49) == 0) en_v = !en_v;
         step();
      end
      en_v = 1'b1;

      // asynchronous reset mid-window
      run_until_pos(40, 4);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      rst_n = 1'b1;
      model_reset();
      pat = 2;
      wait_valid(n);
      check_eq("restart_len", 64'(n), 64'd101);
      check_eq("restart_ovf4", 64'(ovf4), 64'd1);
      run_until_pos(0, 2);
      check_eq("restart_p4", 64'(count32), 64'd25);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
